// File: rtl/rvvi_tx_framer.sv
// Frames RVVI instruction records into 32-bit words: header, zero-padded payload (LSW first).
// Optional mod-2^32 checksum trailer when RVVI_TX_CHECKSUM_EN is defined.
module rvvi_tx_framer #(
  parameter int WIDTH = 792,
  parameter int WORDS = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [WIDTH-1:0] InstrData,
  output logic             InstrStall,
  input  logic             ReplayValid,
  input  logic [WIDTH-1:0] ReplayData,
  output logic             ReplayStall,
  output logic [31:0]      TxData,
  output logic             TxValid,
  input  logic             TxReady,
  output logic             TxLast
);

`ifdef RVVI_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

  localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);

  state_t                   state, state_next;
  logic [15:0]              seq_num;
  logic [4:0]               word_cnt;
  logic [WORDS-1:0][31:0]   rec;
  logic                     replay_flag;
  logic [WORDS*32-1:0]      pad;
  logic [31:0]              hdr;
  logic                     busy;
`ifdef RVVI_TX_CHECKSUM_EN
  logic [31:0]              csum;
`endif

  assign hdr  = {8'h52, replay_flag, 7'd0, seq_num};
  assign busy = (state != IDLE) && !reset;

  // Stalls depend only on registered state (plus ReplayValid for the instruction side).
  assign ReplayStall = busy;
  assign InstrStall  = busy || ReplayValid;
  assign TxValid     = busy;

  always_comb begin
    pad = '0;
    pad[WIDTH-1:0] = ReplayValid ? ReplayData : InstrData;
  end

  always_comb begin
    state_next = state;
    TxData     = '0;
    TxLast     = 1'b0;
    case (state)
      IDLE: begin
        if (ReplayValid || InstrValid) state_next = HEADER;
      end
      HEADER: begin
        TxData = hdr;
        if (TxReady) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        TxData = rec[word_cnt];
`ifdef RVVI_TX_CHECKSUM_EN
        if (TxReady && word_cnt == LAST_WORD) state_next = TRAILER;
`else
        TxLast = (word_cnt == LAST_WORD);
        if (TxReady && word_cnt == LAST_WORD) state_next = IDLE;
`endif
      end
`ifdef RVVI_TX_CHECKSUM_EN
      TRAILER: begin
        TxData = csum;
        TxLast = 1'b1;
        if (TxReady) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
    if (reset) begin
      TxData = '0;
      TxLast = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      seq_num     <= '0;
      word_cnt    <= '0;
      rec         <= '0;
      replay_flag <= 1'b0;
`ifdef RVVI_TX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state <= state_next;
      // Capture only from IDLE; replay wins when both sources are valid.
      if (state == IDLE && (ReplayValid || InstrValid)) begin
        rec         <= pad;
        replay_flag <= ReplayValid;
        word_cnt    <= '0;
`ifdef RVVI_TX_CHECKSUM_EN
        csum        <= '0;
`endif
      end
      if (state == PAYLOAD && TxReady && word_cnt != LAST_WORD)
        word_cnt <= word_cnt + 5'd1;
      if (TxLast && TxReady)
        seq_num <= seq_num + 16'd1;
`ifdef RVVI_TX_CHECKSUM_EN
      if (state == HEADER && TxReady)
        csum <= hdr;
      else if (state == PAYLOAD && TxReady)
        csum <= csum + TxData;
`endif
    end
  end

endmodule

// File: tb/tb_rvvi_tx_framer.sv
// Directed self-checking bench for rvvi_tx_framer (default parameters).
module tb_rvvi_tx_framer;
  localparam int WIDTH = 792;
  localparam int WORDS = 25;

  logic             clk = 1'b0;
  logic             reset;
  logic             InstrValid;
  logic [WIDTH-1:0] InstrData;
  logic             InstrStall;
  logic             ReplayValid;
  logic [WIDTH-1:0] ReplayData;
  logic             ReplayStall;
  logic [31:0]      TxData;
  logic             TxValid;
  logic             TxReady;
  logic             TxLast;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got [32];
  int          n;
  int          last_idx;
  int          viol;
  logic        done;

  rvvi_tx_framer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .InstrValid(InstrValid), .InstrData(InstrData), .InstrStall(InstrStall),
    .ReplayValid(ReplayValid), .ReplayData(ReplayData), .ReplayStall(ReplayStall),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .TxLast(TxLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; InstrValid = 1'b0; ReplayValid = 1'b0; TxReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_instr(input logic [WIDTH-1:0] d);
    InstrData = d; InstrValid = 1'b1;
    @(posedge clk);
    #1 InstrValid = 1'b0;
  endtask

  // Accept words until TxLast is taken; mode 1 toggles TxReady after a few words.
  task automatic collect(input int mode);
    logic        held;
    logic [31:0] hd;
    logic        hl;
    n = 0; last_idx = -1; viol = 0; done = 1'b0; held = 1'b0; hd = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (held && (!TxValid || TxData !== hd || TxLast !== hl)) viol++;
      held = TxValid && !TxReady; hd = TxData; hl = TxLast;
      if (TxValid && TxReady) begin
        if (n < 32) got[n] = TxData;
        if (TxLast) begin last_idx = n; done = 1'b1; end
        n++;
      end
      @(posedge clk);
      #1;
      if (mode == 1) TxReady = (cyc < 3) ? 1'b1 : ((cyc % 2) == 1);
    end
    TxReady = 1'b1;
    chk("frame_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [31:0]      orv;
    int               bad;
    logic [31:0]      sum;
    logic             saw_last;

    InstrData = '0; ReplayData = '0; TxReady = 1'b1;
    InstrValid = 1'b0; ReplayValid = 1'b0; reset = 1'b1;

    // Reset-state outputs, with ReplayValid high to see InstrStall follow it.
    ReplayValid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_txvalid", {63'd0, TxValid}, 64'd0);
    chk("rst_txlast", {63'd0, TxLast}, 64'd0);
    chk("rst_txdata", {32'd0, TxData}, 64'd0);
    chk("rst_replaystall", {63'd0, ReplayStall}, 64'd0);
    chk("rst_instrstall", {63'd0, InstrStall}, 64'd1);
    do_reset();
    @(negedge clk);
    chk("idle_txvalid", {63'd0, TxValid}, 64'd0);
    @(posedge clk); #1;

    // Basic frame with record 1.
    d = '0; d[0] = 1'b1;
    start_instr(d);
    collect(0);
    chk("f1_words", n, 26);
    chk("f1_header", {32'd0, got[0]}, 64'h5200_0000);
    chk("f1_word0", {32'd0, got[1]}, 64'h1);
    orv = '0;
    for (int i = 2; i < 26; i++) orv |= got[i];
    chk("f1_zero_pad", {32'd0, orv}, 64'd0);
    chk("f1_last_idx", last_idx, 25);
    start_instr('0);
    collect(0);
    chk("f2_header_seq1", {32'd0, got[0]}, 64'h5200_0001);

    // Replay and instruction in the same IDLE cycle.
    do_reset();
    ReplayData = '0; ReplayData[15:0] = 16'hABCD;
    InstrData = '0; InstrData[3:0] = 4'h5;
    ReplayValid = 1'b1; InstrValid = 1'b1;
    #3;
    chk("both_instrstall_idle", {63'd0, InstrStall}, 64'd1);
    chk("both_replaystall_idle", {63'd0, ReplayStall}, 64'd0);
    @(posedge clk); #1;
    ReplayValid = 1'b0;
    #3;
    chk("both_instrstall_busy", {63'd0, InstrStall}, 64'd1);
    chk("both_replaystall_busy", {63'd0, ReplayStall}, 64'd1);
    collect(0);
    chk("replay_header", {32'd0, got[0]}, 64'h5280_0000);
    chk("replay_word0", {32'd0, got[1]}, 64'hABCD);
    @(posedge clk); #1;
    InstrValid = 1'b0;
    collect(0);
    chk("instr_header", {32'd0, got[0]}, 64'h5200_0001);
    chk("instr_word0", {32'd0, got[1]}, 64'h5);

    // Backpressure with TxReady toggling mid-payload.
    do_reset();
    d = '0;
    for (int i = 0; i < WORDS; i++) d[i*32 +: 24] = 24'hA00000 + 24'(i);
    start_instr(d);
    collect(1);
    chk("bp_words", n, 26);
    chk("bp_stable", viol, 0);
    chk("bp_last_idx", last_idx, 25);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (got[i+1] !== 32'h00A0_0000 + 32'(i)) bad++;
    chk("bp_payload", bad, 0);

    // SeqNum wrap.
    do_reset();
    force dut.seq_num = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq_num;
    start_instr('0);
    collect(0);
    chk("wrap_hdr_ffff", {48'd0, got[0][15:0]}, 64'hFFFF);
    start_instr('0);
    collect(0);
    chk("wrap_hdr_0000", {48'd0, got[0][15:0]}, 64'h0000);

    // Reset on payload word 10.
    do_reset();
    d = '0; d[0] = 1'b1;
    start_instr(d);
    saw_last = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (TxLast) saw_last = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("abort_on_word10", {32'd0, TxData}, 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    if (TxLast) saw_last = 1'b1;
    chk("abort_txvalid", {63'd0, TxValid}, 64'd0);
    chk("abort_no_txlast", {63'd0, saw_last}, 64'd0);
    @(posedge clk); #1;
    d = '0; d[1] = 1'b1;
    start_instr(d);
    collect(0);
    chk("abort_next_header", {32'd0, got[0]}, 64'h5200_0000);
    chk("abort_next_word0", {32'd0, got[1]}, 64'h2);

`ifdef RVVI_TX_CHECKSUM_EN
    do_reset();
    start_instr('1);
    collect(0);
    sum = 32'h5200_0000;
    for (int i = 0; i < WORDS - 1; i++) sum += 32'hFFFF_FFFF;
    sum += 32'h00FF_FFFF;
    chk("cs_words", n, 27);
    chk("cs_last_idx", last_idx, 26);
    chk("cs_trailer", {32'd0, got[26]}, {32'd0, sum});
`else
    sum = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
